// File: rtl/nn_mac_sequencer.sv
// nn_mac_sequencer: computes one neuron output, bias + sum(x[i]*w[i]),
// then an arithmetic right-shift rescale and optional ReLU. It sequences a
// shared combinational 32-bit ALU and reads x/w pairs from an operand
// buffer that has a 1-cycle read latency.
module nn_mac_sequencer #(
   parameter int ADDR_W  = 8,
   parameter bit RELU_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W:0]          num_inputs,
   input  logic signed [31:0]       bias,
   input  logic [4:0]               shift_amt,
   output logic                     mem_rd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic signed [31:0]       mem_x,
   input  logic signed [31:0]       mem_w,
   output logic signed [31:0]       alu_op1,
   output logic signed [31:0]       alu_op2,
   output logic [3:0]               alu_op,
   input  logic signed [31:0]       alu_result,
   input  logic                     alu_ovf,
   input  logic                     alu_zero,
   output logic                     busy,
   output logic                     done,
   output logic signed [31:0]       result,
   output logic                     ovf,
   output logic                     zero
);

   localparam logic [3:0] OP_MULT = 4'b0110;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_MULT,
      S_ACC,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic signed [31:0] acc;
   logic signed [31:0] prod;
   logic [ADDR_W:0]    idx;
   logic [ADDR_W:0]    idx_inc;
   logic [ADDR_W:0]    n_q;
   logic [4:0]         sh_q;
   logic signed [31:0] relu_v;

   // The controller derives its own zero flag after the ReLU clamp, so the
   // ALU zero flag carries no information it needs.
   logic alu_zero_unused;
   assign alu_zero_unused = alu_zero;

   // Optional ReLU: negative rescaled values clamp to zero.
   function automatic logic signed [31:0] relu_clamp(input logic signed [31:0] v);
      if (RELU_EN && v[31]) return '0;
      return v;
   endfunction

   // idx is one bit wider than the address so a full buffer (N = 2^ADDR_W)
   // terminates without the counter aliasing back to zero.
   assign idx_inc = idx + 1'b1;
   assign relu_v  = relu_clamp(alu_result);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and per-state ALU / operand-buffer drive.
   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      alu_op1   = '0;
      alu_op2   = '0;
      alu_op    = OP_ADD;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (num_inputs == '0) ? S_SHIFT : S_FETCH;
         end
         S_FETCH: begin
            mem_rd    = 1'b1;
            mem_addr  = idx[ADDR_W-1:0];
            state_nxt = S_MULT;
         end
         S_MULT: begin
            alu_op1   = mem_x;
            alu_op2   = mem_w;
            alu_op    = OP_MULT;
            state_nxt = S_ACC;
         end
         S_ACC: begin
            alu_op1   = acc;
            alu_op2   = prod;
            alu_op    = OP_ADD;
            state_nxt = (idx_inc == n_q) ? S_SHIFT : S_FETCH;
         end
         S_SHIFT: begin
            alu_op1   = acc;
            alu_op2   = {27'b0, sh_q};
            alu_op    = OP_SRA;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Handshake and result registers: busy/done track the state being
   // entered, ovf is sticky for one neuron, result/zero load in SHIFT.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         result <= '0;
         zero   <= 1'b0;
      end else begin
         busy <= (state_nxt != S_IDLE);
         done <= (state_nxt == S_DONE);
         case (state)
            S_IDLE: begin
               if (start) ovf <= 1'b0;
            end
            S_MULT, S_ACC: begin
               ovf <= ovf | alu_ovf;
            end
            S_SHIFT: begin
               result <= relu_v;
               zero   <= (relu_v == '0);
            end
            default: ;
         endcase
      end
   end

   // Accumulator datapath: operands latched on start, product and running
   // sum captured from the ALU at the end of MULT and ACC respectively.
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: begin
            if (start) begin
               acc  <= bias;
               n_q  <= num_inputs;
               sh_q <= shift_amt;
               idx  <= '0;
            end
         end
         S_MULT: begin
            prod <= alu_result;
         end
         S_ACC: begin
            acc <= alu_result;
            idx <= idx_inc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Bench for nn_mac_sequencer: two instances (ReLU off / on) share stimulus,
// each with its own operand buffer and combinational ALU. A schedule-level
// reference model predicts every cycle's outputs from the element count.
module tb_nn_mac_sequencer;

   localparam int AW = 4;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start;
   logic [AW:0]   num_inputs;
   logic [31:0]   bias;
   logic [4:0]    shift_amt;

   logic          mem_rd0, mem_rd1;
   logic [AW-1:0] mem_addr0, mem_addr1;
   logic [31:0]   mx0, mw0, mx1, mw1;
   logic [31:0]   aop1_0, aop2_0, aop1_1, aop2_1;
   logic [3:0]    aop0, aop1;
   logic [31:0]   ares0, ares1;
   logic          aovf0, aovf1, azero0, azero1;
   logic          busy0, busy1, done0, done1, ovf0, ovf1, zero0, zero1;
   logic [31:0]   res0, res1;

   int xm[DEPTH];
   int wm[DEPTH];

   int n_tests = 0;
   int n_fail  = 0;

   nn_mac_sequencer #(.ADDR_W(AW), .RELU_EN(1'b0)) u0 (
      .clk(clk), .rst(rst), .start(start), .num_inputs(num_inputs), .bias(bias),
      .shift_amt(shift_amt), .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_x(mx0),
      .mem_w(mw0), .alu_op1(aop1_0), .alu_op2(aop2_0), .alu_op(aop0),
      .alu_result(ares0), .alu_ovf(aovf0), .alu_zero(azero0), .busy(busy0),
      .done(done0), .result(res0), .ovf(ovf0), .zero(zero0));

   nn_mac_sequencer #(.ADDR_W(AW), .RELU_EN(1'b1)) u1 (
      .clk(clk), .rst(rst), .start(start), .num_inputs(num_inputs), .bias(bias),
      .shift_amt(shift_amt), .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_x(mx1),
      .mem_w(mw1), .alu_op1(aop1_1), .alu_op2(aop2_1), .alu_op(aop1),
      .alu_result(ares1), .alu_ovf(aovf1), .alu_zero(azero1), .busy(busy1),
      .done(done1), .result(res1), .ovf(ovf1), .zero(zero1));

   // Combinational ALU: returns {overflow, result}.
   function automatic logic [32:0] alu(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      logic signed [63:0] p;
      logic signed [32:0] s;
      logic [31:0] r;
      logic v;
      r = '0;
      v = 1'b0;
      case (op)
         4'b0110: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = p[31:0];
            v = (p != {{32{p[31]}}, p[31:0]});
         end
         4'b0100: begin
            s = $signed({a[31], a}) + $signed({b[31], b});
            r = s[31:0];
            v = (s[32] != s[31]);
         end
         4'b0010: r = $signed(a) >>> b[4:0];
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   assign {aovf0, ares0} = alu(aop0, aop1_0, aop2_0);
   assign {aovf1, ares1} = alu(aop1, aop1_1, aop2_1);
   assign azero0 = (ares0 == '0);
   assign azero1 = (ares1 == '0);

   // Operand buffers with 1-cycle read latency.
   always @(posedge clk) begin
      if (mem_rd0) begin
         mx0 <= xm[mem_addr0];
         mw0 <= wm[mem_addr0];
      end
      if (mem_rd1) begin
         mx1 <= xm[mem_addr1];
         mw1 <= wm[mem_addr1];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          active = 1'b0;
   int          ph = 0;
   int          n_m = 0;
   int          e_res0 = 0, e_res1 = 0, e_pre = 0, e_sh = 0;
   bit          e_ovf = 1'b0;
   logic [31:0] res0_m = '0, res1_m = '0;
   bit          ovf_m = 1'b0, z0_m = 1'b0, z1_m = 1'b0;

   task automatic model_compute(input int n, input logic [31:0] b, input logic [4:0] sh);
      longint a, p;
      bit v;
      int r;
      a = longint'($signed(b));
      v = 1'b0;
      for (int i = 0; i < n; i++) begin
         p = longint'(xm[i]) * longint'(wm[i]);
         if (p != longint'(int'(p))) v = 1'b1;
         p = longint'(int'(p));
         a = a + p;
         if (a != longint'(int'(a))) v = 1'b1;
         a = longint'(int'(a));
      end
      e_pre  = int'(a);
      r      = int'(a) >>> sh;
      e_res0 = r;
      e_res1 = (r < 0) ? 0 : r;
      e_ovf  = v;
      e_sh   = int'(sh);
   endtask

   initial begin : model_cmp
      int last;
      bit fetch;
      logic [3:0] eop;
      forever begin
         @(posedge clk);
         if (rst) begin
            active = 1'b0;
            res0_m = '0; res1_m = '0; ovf_m = 1'b0; z0_m = 1'b0; z1_m = 1'b0;
         end else if (active) begin
            if (ph == 3 * n_m + 2) active = 1'b0;
            else begin
               ph++;
               if (ph == 3 * n_m + 2) begin
                  res0_m = e_res0; res1_m = e_res1; ovf_m = e_ovf;
                  z0_m = (e_res0 == 0); z1_m = (e_res1 == 0);
               end
            end
         end else if (start) begin
            n_m = int'(num_inputs);
            model_compute(n_m, bias, shift_amt);
            ph = 1;
            active = 1'b1;
         end

         @(negedge clk);
         last = 3 * n_m + 2;
         if (active) begin
            fetch = (ph <= 3 * n_m) && (ph % 3 == 1);
            chk("busy0", busy0, 1);
            chk("busy1", busy1, 1);
            chk("done0", done0, ph == last);
            chk("done1", done1, ph == last);
            chk("mem_rd0", mem_rd0, fetch);
            chk("mem_rd1", mem_rd1, fetch);
            if (fetch) chk("mem_addr0", mem_addr0, ((ph - 1) / 3) % DEPTH);
            if (ph <= 3 * n_m) begin
               if (ph % 3 == 2) begin
                  eop = 4'b0110;
                  chk("mult_op1", aop1_0, xm[(ph - 2) / 3]);
                  chk("mult_op2", aop2_0, wm[(ph - 2) / 3]);
               end else begin
                  eop = 4'b0100;
                  if (ph % 3 == 1) begin
                     chk("fetch_op1", aop1_0, 0);
                     chk("fetch_op2", aop2_0, 0);
                  end
               end
            end else if (ph == 3 * n_m + 1) begin
               eop = 4'b0010;
               chk("sra_op1", aop1_0, e_pre);
               chk("sra_op2", aop2_0, e_sh);
            end else begin
               eop = 4'b0100;
            end
            chk("alu_op0", aop0, eop);
            chk("alu_op1", aop1, eop);
            if (ph == last) begin
               chk("done_res0", res0, res0_m);
               chk("done_res1", res1, res1_m);
               chk("done_ovf0", ovf0, ovf_m);
               chk("done_ovf1", ovf1, ovf_m);
               chk("done_zero0", zero0, z0_m);
               chk("done_zero1", zero1, z1_m);
            end
         end else begin
            chk("idle_busy0", busy0, 0);
            chk("idle_busy1", busy1, 0);
            chk("idle_done0", done0, 0);
            chk("idle_done1", done1, 0);
            chk("idle_mem_rd0", mem_rd0, 0);
            chk("idle_alu_op0", aop0, 4'b0100);
            chk("idle_op1", aop1_0, 0);
            chk("idle_op2", aop2_0, 0);
            chk("idle_res0", res0, res0_m);
            chk("idle_res1", res1, res1_m);
            chk("idle_ovf0", ovf0, ovf_m);
            chk("idle_zero0", zero0, z0_m);
            chk("idle_zero1", zero1, z1_m);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_op(input int n, input logic [31:0] b, input logic [4:0] sh);
      @(negedge clk);
      start = 1'b1;
      num_inputs = n[AW:0];
      bias = b;
      shift_amt = sh;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs one neuron; lat counts cycles from start-sampling edge to done.
   // A nonzero spur_at pulses start again in that cycle (must be ignored).
   task automatic run(input int n, input logic [31:0] b, input logic [4:0] sh,
                      input int spur_at, output int lat, output int rds);
      start_op(n, b, sh);
      lat = 1;
      rds = int'(mem_rd0);
      while (!done0 && lat < 400) begin
         @(negedge clk);
         lat++;
         rds += int'(mem_rd0);
         start = (spur_at != 0 && lat == spur_at);
         if (start) begin
            num_inputs = 1;
            bias = 32'd99;
         end
      end
      if (!done0) chk("done_timeout", 0, 1);
      if (start) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic load_t1();
      xm[0] = 1; xm[1] = 2; xm[2] = 3;
      wm[0] = 4; wm[1] = -5; wm[2] = 6;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int lat, rds, n, mode;
      rst = 1'b1; start = 1'b0; num_inputs = '0; bias = '0; shift_amt = '0;
      for (int i = 0; i < DEPTH; i++) begin xm[i] = 0; wm[i] = 0; end
      repeat (3) @(negedge clk);
      chk("rst_result", res0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_alu_op", aop0, 4'b0100);
      chk("rst_ovf", ovf0, 0);
      rst = 1'b0;

      // Basic MAC
      load_t1();
      run(3, 32'd5, 5'd0, 0, lat, rds);
      chk("t1_latency", lat, 11);
      chk("t1_reads", rds, 3);
      chk("t1_result", res0, 17);
      chk("t1_ovf", ovf0, 0);
      chk("t1_zero", zero0, 0);

      // Rescale + ReLU
      xm[0] = -16; wm[0] = 1;
      run(1, 32'd0, 5'd2, 0, lat, rds);
      chk("t2_result_norelu", res0, 32'hFFFFFFFC);
      chk("t2_result_relu", res1, 0);
      chk("t2_zero_relu", zero1, 1);
      chk("t2_zero_norelu", zero0, 0);

      // Empty neuron
      run(0, -32'sd7, 5'd0, 0, lat, rds);
      chk("t3_latency", lat, 2);
      chk("t3_reads", rds, 0);
      chk("t3_result", res0, 32'hFFFFFFF9);

      // Overflow, then cleared by the next start
      xm[0] = 1; wm[0] = 1;
      run(1, 32'h7FFFFFFF, 5'd0, 0, lat, rds);
      chk("t4_result", res0, 32'h80000000);
      chk("t4_ovf", ovf0, 1);
      chk("t4_ovf_relu", ovf1, 1);
      @(negedge clk);
      chk("t4_ovf_held", ovf0, 1);
      run(1, 32'd0, 5'd0, 0, lat, rds);
      chk("t4_ovf_cleared", ovf0, 0);
      chk("t4_benign_result", res0, 1);

      // Start during MULT and during DONE is ignored
      load_t1();
      run(3, 32'd5, 5'd0, 2, lat, rds);
      chk("t5_spur_latency", lat, 11);
      chk("t5_spur_result", res0, 17);
      run(1, 32'd0, 5'd0, 5, lat, rds);
      chk("t5_done_start_busy", busy0, 0);

      // Reset in ACC aborts; a fresh start then completes
      start_op(3, 32'd5, 5'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_busy", busy0, 0);
      chk("t5_rst_result", res0, 0);
      chk("t5_rst_done", done0, 0);
      run(3, 32'd5, 5'd0, 0, lat, rds);
      chk("t5_after_rst_result", res0, 17);

      // Full-depth buffer: idx must reach 2^ADDR_W without aliasing
      for (int i = 0; i < DEPTH; i++) begin xm[i] = i + 1; wm[i] = 2; end
      run(DEPTH, 32'd0, 5'd0, 0, lat, rds);
      chk("full_latency", lat, 3 * DEPTH + 2);
      chk("full_reads", rds, DEPTH);
      chk("full_result", res0, DEPTH * (DEPTH + 1));

      // Randomized neurons, with occasional spurious starts and aborts
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < DEPTH; i++) begin
            xm[i] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
            wm[i] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
         end
         n = int'($urandom_range(0, DEPTH));
         mode = int'($urandom_range(0, 7));
         if (mode == 0) begin
            start_op(n, $urandom, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3 * n)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            run(n, ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 100)),
                5'($urandom_range(0, 31)), (mode == 1) ? 2 : 0, lat, rds);
            chk("rand_latency", lat, 3 * n + 2);
            chk("rand_reads", rds, n);
         end
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nn_mac_sequencer.md
Name: nn_mac_sequencer

Overview:
- Controller that computes one neuron output, bias + sum(x[i]*w[i]), followed by an arithmetic right-shift rescale and optional ReLU.
- Sequences the shared 32-bit ALU by driving op1/op2/alu_op and consuming result/ovf/zero.
- Fetches input/weight pairs from an operand buffer with 1-cycle read latency.
- Sits between the layer controller, which issues start/num_inputs/bias, and the ALU datapath.

Parameters:
ADDR_W, 8, operand-buffer address width; max num_inputs = 2^ADDR_W
RELU_EN, 1, 1 = clamp negative final result to 0; 0 = pass through

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a neuron computation; sampled only in IDLE
num_inputs  input  ADDR_W+1  element count N (0..2^ADDR_W), latched on start
bias  input  32  signed initial accumulator value, latched on start
shift_amt  input  5  SRA amount for final rescale, latched on start
mem_rd  output  1  operand-buffer read strobe
mem_addr  output  ADDR_W  element index
mem_x  input  32  signed input activation, valid 1 cycle after mem_rd
mem_w  input  32  signed weight, valid 1 cycle after mem_rd
alu_op1  output  32  ALU operand 1
alu_op2  output  32  ALU operand 2
alu_op  output  4  ALU opcode
alu_result  input  32  ALU combinational result
alu_ovf  input  1  ALU overflow flag
alu_zero  input  1  ALU zero flag
busy  output  1  high from the cycle after start through the DONE state
done  output  1  one-cycle pulse; result/ovf valid
result  output  32  signed neuron output, held until next start
ovf  output  1  sticky overflow across all MULT/ADD steps of this neuron
zero  output  1  result == 0, registered with result

Behaviour:
- Reset (synchronous, active-high): state=IDLE. busy, done, mem_rd, ovf and zero are 0. result, mem_addr, alu_op1 and alu_op2 are 0. alu_op=4'b0100 (ADD).
- A reset asserted mid-operation aborts immediately. It produces no done pulse.
- Opcodes driven: MULT=4'b0110, ADD=4'b0100, SRA=4'b0010.
- Registers: acc[31:0], prod[31:0], idx[ADDR_W:0], N_q, sh_q.

State machine:
- IDLE: ALU drive op1=op2=0, op=ADD.
  - On start: acc<=bias, N_q<=num_inputs, sh_q<=shift_amt, idx<=0, ovf<=0.
  - Next state is FETCH, or SHIFT if num_inputs==0.
- FETCH: mem_rd=1, mem_addr=idx[ADDR_W-1:0]. Next state MULT.
- MULT: op1=mem_x, op2=mem_w, op=MULT.
  - prod<=alu_result; ovf<=ovf|alu_ovf.
  - Next state ACC.
- ACC: op1=acc, op2=prod, op=ADD.
  - acc<=alu_result (32-bit wrap); ovf<=ovf|alu_ovf; idx<=idx+1.
  - Next state SHIFT if idx+1==N_q, else FETCH.
- SHIFT: op1=acc, op2={27'b0,sh_q}, op=SRA.
  - result<=(RELU_EN && alu_result[31]) ? 0 : alu_result.
  - zero<=(value written to result)==0.
  - Next state DONE.
- DONE: done=1 for exactly this cycle. Next state IDLE.

Timing and handshake:
- busy=1 in FETCH/MULT/ACC/SHIFT/DONE. busy is a registered output, high the cycle after start is sampled.
- Latency: start sampled at edge T leads to done high in cycle T+3N+2. N=0 gives T+2.
- Start while busy is ignored, including in the DONE cycle. Start in IDLE on the cycle after DONE is accepted.
- mem_rd is high only in FETCH, and at most one read is outstanding.
- mem_x/mem_w are consumed only in MULT, i.e. exactly 1 cycle after mem_rd.
- ALU outputs are combinational from the current state. Results are captured at the end of the same cycle, so the ALU must be purely combinational.
- N=2^ADDR_W: idx reaches 2^ADDR_W without aliasing, because idx is ADDR_W+1 bits wide. mem_addr wraps naturally at the last element only.
- ovf is not cleared by done. It clears only on the next accepted start or on rst.
- alu_zero is unused by the controller. The zero output is computed internally after ReLU.

Test Plan:
1. Basic MAC: N=3, bias=5, x={1,2,3}, w={4,-5,6}, shift_amt=0 -> result=17, ovf=0, zero=0. done exactly 11 cycles after start. mem_rd pulses 3 times with addr 0,1,2.
2. Rescale + ReLU: N=1, bias=0, x=-16, w=1, shift_amt=2. RELU_EN=0 -> result=-4 (0xFFFFFFFC). RELU_EN=1 -> result=0, zero=1.
3. Empty neuron: N=0, bias=-7, shift_amt=0, RELU_EN=0 -> no mem_rd, done 2 cycles after start, result=-7.
4. Overflow: N=1, bias=32'h7FFFFFFF, x=1, w=1, RELU_EN=0 -> result=32'h80000000, ovf=1. Next start with benign data -> ovf returns to 0.
5. Handshake/reset: start pulsed again during MULT -> ignored, same done count/result as test 1. rst asserted in ACC -> next cycle state IDLE, busy=0, done never pulses, result=0. A fresh start then completes normally.
6. ALU sequencing check: monitor alu_op per cycle in test 1 -> 0110,0100 repeated 3x, each pair preceded by a FETCH cycle, then 0010 once, then 0100 in DONE/IDLE.
